// File: rtl/conv_addr_sched.sv
// Sliding-window convolution address scheduler: walks every output window and kernel tap.
// Latency: first beat valid the cycle after an accepted start; then one beat per cycle.
// Backpressure: valid && !ready freezes every counter, so all beat outputs hold steady.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start, stride     pass request and window step, sampled together in IDLE
//   valid, ready      beat handshake toward the multiply-accumulate path
//   img_addr          row-major image address (or*S+kr)*M + (oc*S+kc)
//   ker_addr          row-major kernel address kr*F+kc
//   out_row, out_col  output window position of the current beat
//   win_last          current beat is the last tap of its window
//   busy              pass in progress
//   done              one-cycle pulse after the final beat is accepted
//   err               one-cycle pulse when start arrives with stride 0

module conv_addr_sched #(
   parameter int unsigned M  = 3,
   parameter int unsigned F  = 2,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [3:0]    stride,
   input  logic          ready,
   output logic          valid,
   output logic [AW-1:0] img_addr,
   output logic [AW-1:0] ker_addr,
   output logic [AW-1:0] out_row,
   output logic [AW-1:0] out_col,
   output logic          win_last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   // Internal arithmetic is kept 4 bits wider than the outputs.
   localparam int unsigned IW = AW + 4;

   localparam logic [IW-1:0] ONE   = IW'(1);
   localparam logic [IW-1:0] ZERO  = '0;
   localparam logic [IW-1:0] F_LST = IW'(F - 1);
   localparam logic [IW-1:0] M_F   = IW'(M - F);
   localparam logic [IW-1:0] M_W   = IW'(M);
   localparam logic [IW-1:0] F_W   = IW'(F);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    s_q, s_d;
   logic [IW-1:0] row_q, row_d;
   logic [IW-1:0] col_q, col_d;
   logic [IW-1:0] kr_q, kr_d;
   logic [IW-1:0] kc_q, kc_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [IW-1:0] s_ext;
   logic          fire;
   logic          kc_last, kr_last, col_last, row_last;
   logic [IW-1:0] img_full, ker_full;

   assign s_ext = {{(IW-4){1'b0}}, s_q};
   assign fire  = (state_q == RUN) && ready;

   assign kc_last  = (kc_q == F_LST);
   assign kr_last  = (kr_q == F_LST);
   // A window position is the last along its axis when the next step would
   // push the window past the image edge: pos*S + S > M-F. This gives
   // N = floor((M-F)/S)+1 positions without a runtime divider.
   assign col_last = ((col_q * s_ext) + s_ext) > M_F;
   assign row_last = ((row_q * s_ext) + s_ext) > M_F;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 4'd0;
         row_q   <= '0;
         col_q   <= '0;
         kr_q    <= '0;
         kc_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         row_q   <= row_d;
         col_q   <= col_d;
         kr_q    <= kr_d;
         kc_q    <= kc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------
   // Next state and counter sequencing
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      row_d   = row_q;
      col_d   = col_q;
      kr_d    = kr_q;
      kc_d    = kc_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (stride == 4'd0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = RUN;
                  s_d     = stride;
                  row_d   = ZERO;
                  col_d   = ZERO;
                  kr_d    = ZERO;
                  kc_d    = ZERO;
               end
            end
         end

         RUN: begin
            // Nesting, innermost first: kc, kr, col, row. start/stride are
            // deliberately ignored here.
            if (fire) begin
               if (!kc_last) begin
                  kc_d = kc_q + ONE;
               end else begin
                  kc_d = ZERO;
                  if (!kr_last) begin
                     kr_d = kr_q + ONE;
                  end else begin
                     kr_d = ZERO;
                     if (!col_last) begin
                        col_d = col_q + ONE;
                     end else begin
                        col_d = ZERO;
                        if (!row_last) begin
                           row_d = row_q + ONE;
                        end else begin
                           // Final beat accepted: counters are already back at 0.
                           row_d   = ZERO;
                           state_d = IDLE;
                           done_d  = 1'b1;
                        end
                     end
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Beat outputs, derived directly from the counters so they stay
   // stable for as long as the counters are frozen by backpressure.
   // ---------------------------------------------------------------
   assign img_full = (((row_q * s_ext) + kr_q) * M_W) + (col_q * s_ext) + kc_q;
   assign ker_full = (kr_q * F_W) + kc_q;

   assign valid    = (state_q == RUN);
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign err      = err_q;
   assign img_addr = img_full[AW-1:0];
   assign ker_addr = ker_full[AW-1:0];
   assign out_row  = row_q[AW-1:0];
   assign out_col  = col_q[AW-1:0];
   // Gated by valid so F=1 does not raise it while idle.
   assign win_last = (state_q == RUN) && kc_last && kr_last;

   // Upper guard bits never reach the outputs for legal parameters.
   logic unused_hi;
   assign unused_hi = ^{img_full[IW-1:AW], ker_full[IW-1:AW],
                        row_q[IW-1:AW], col_q[IW-1:AW]};

endmodule

// File: tb/tb_conv_addr_sched.sv
module tb_conv_addr_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] stride;
   logic       ready;
   logic       sel;   // 0: 3x3 image / 2x2 kernel instance, 1: 5x5 / 3x3 instance

   always #5 clk = ~clk;

   logic       a_valid, a_last, a_busy, a_done, a_err;
   logic [7:0] a_img, a_ker, a_row, a_col;
   logic       b_valid, b_last, b_busy, b_done, b_err;
   logic [7:0] b_img, b_ker, b_row, b_col;

   conv_addr_sched #(.M(3), .F(2), .AW(8)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .stride(stride), .ready(ready),
      .valid(a_valid), .img_addr(a_img), .ker_addr(a_ker), .out_row(a_row),
      .out_col(a_col), .win_last(a_last), .busy(a_busy), .done(a_done), .err(a_err)
   );

   conv_addr_sched #(.M(5), .F(3), .AW(8)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .stride(stride), .ready(ready),
      .valid(b_valid), .img_addr(b_img), .ker_addr(b_ker), .out_row(b_row),
      .out_col(b_col), .win_last(b_last), .busy(b_busy), .done(b_done), .err(b_err)
   );

   typedef struct packed {
      logic [7:0] img;
      logic [7:0] ker;
      logic [7:0] row;
      logic [7:0] col;
      logic       last;
   } beat_t;

   logic  ob_valid, ob_busy, ob_done, ob_err;
   beat_t obs;
   assign ob_valid = sel ? b_valid : a_valid;
   assign ob_busy  = sel ? b_busy  : a_busy;
   assign ob_done  = sel ? b_done  : a_done;
   assign ob_err   = sel ? b_err   : a_err;
   assign obs = sel ? {b_img, b_ker, b_row, b_col, b_last}
                    : {a_img, a_ker, a_row, a_col, a_last};

   beat_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: enumerate windows and taps from the closed-form extent.
   task automatic push_exp(input int m, input int f, input int s);
      int    n;
      beat_t b;
      n = (m - f) / s + 1;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int kr = 0; kr < f; kr++)
               for (int kc = 0; kc < f; kc++) begin
                  b.img  = 8'((r * s + kr) * m + (c * s + kc));
                  b.ker  = 8'(kr * f + kc);
                  b.row  = 8'(r);
                  b.col  = 8'(c);
                  b.last = (kr == f - 1) && (kc == f - 1);
                  exp_q.push_back(b);
               end
   endtask

   typedef struct {
      int dsel;
      int s;
      int stall;
      int poke;
      int lit;
      int exp_beats;
   } vec_t;

   vec_t vecs[8];
   int   img1[16];

   task automatic run_vec(input vec_t v);
      int    cyc, beats, stalls;
      bit    have_hold;
      beat_t held, b;
      sel = v.dsel[0];
      push_exp(v.dsel != 0 ? 5 : 3, v.dsel != 0 ? 3 : 2, v.s);
      @(negedge clk);
      stride = 4'(v.s);
      start  = 1'b1;
      ready  = 1'b0;
      @(posedge clk);
      #1;
      start  = 1'b0;
      stride = 4'd7;   // must be ignored while running
      cyc = 0; beats = 0; stalls = 0; have_hold = 0; held = '0;
      while (exp_q.size() > 0 && cyc < 2000) begin
         @(negedge clk);
         ready = (v.stall != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         start = (v.poke != 0 && cyc == 5);
         if (cyc == 0) check("first_busy", 64'(ob_busy), 64'd1);
         if (!ob_valid) check("valid_dropped", 64'(ob_valid), 64'd1);
         if (have_hold) check("stall_hold", 64'(obs), 64'(held));
         if (ob_valid && ready) begin
            b = exp_q.pop_front();
            check("beat", 64'(obs), 64'(b));
            if (v.lit != 0 && beats < 16) check("img_seq", 64'(obs.img), 64'(img1[beats]));
            beats++;
            have_hold = 0;
         end else if (ob_valid) begin
            held = obs;
            have_hold = 1;
            stalls++;
         end
         cyc++;
      end
      start = 1'b0;
      if (exp_q.size() != 0) begin
         check("timeout_remaining", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      check("beat_count", 64'(beats), 64'(v.exp_beats));
      check("cycle_count", 64'(cyc), 64'(beats + stalls));
      @(negedge clk);
      ready = 1'b1;
      check("done_pulse", 64'({ob_done, ob_valid, ob_busy}), 64'b100);
      @(negedge clk);
      check("done_clear", 64'({ob_done, ob_valid, ob_busy}), 64'b000);
   endtask

   initial begin
      beat_t b;
      img1 = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
      //          dsel s   stall poke lit beats
      vecs[0] = '{0,   1,  0,    0,   1,  16};
      vecs[1] = '{0,   2,  0,    0,   0,  4};
      vecs[2] = '{0,   15, 0,    0,   0,  4};
      vecs[3] = '{1,   2,  0,    0,   0,  36};
      vecs[4] = '{1,   1,  0,    0,   0,  81};
      vecs[5] = '{1,   3,  0,    0,   0,  9};
      vecs[6] = '{0,   1,  1,    0,   1,  16};
      vecs[7] = '{0,   1,  0,    1,   1,  16};

      rst = 1'b1; start = 1'b0; stride = 4'd0; ready = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_a", 64'({a_valid, a_busy, a_done, a_err, a_last, a_img, a_ker, a_row, a_col}), 64'd0);
      check("reset_b", 64'({b_valid, b_busy, b_done, b_err, b_last, b_img, b_ker, b_row, b_col}), 64'd0);
      rst = 1'b0;

      // start with stride 0: err pulse only
      @(negedge clk);
      start = 1'b1; stride = 4'd0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("err_pulse", 64'({ob_err, ob_valid, ob_busy}), 64'b100);
      @(negedge clk);
      check("err_clear", 64'({ob_err, ob_valid, ob_busy}), 64'b000);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset after beat 6 of a stride-1 pass, then a clean restart
      sel = 1'b0;
      push_exp(3, 2, 1);
      @(negedge clk);
      start = 1'b1; stride = 4'd1; ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         b = exp_q.pop_front();
         check("pre_rst_beat", 64'(obs), 64'(b));
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid", 64'({ob_valid, ob_busy, ob_done, ob_err, obs}), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_stays_idle", 64'({ob_valid, ob_busy, ob_done}), 64'd0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_addr_sched.md
# conv_addr_sched

Address scheduler that sequences the sliding-window convolution datapath. Given an M×M image and an F×F kernel in row-major memory, plus a runtime stride, it walks every output position and every kernel tap. Each beat carries one (image address, kernel address) pair, window position and end-of-window flag to the multiply-accumulate path under a valid/ready handshake. It sits between the host control that issues `start` and the image/kernel buffers feeding the datapath's `a`/`b` operands.

## Interface
- `M`, 3, image side length (elements); legal range 2..15.
- `F`, 2, kernel side length; legal range 1..M.
- `AW`, 8, width of address and position outputs; must satisfy 2^AW ≥ M*M.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a new pass; sampled only in IDLE.
- `stride`  in  4  window step, sampled with `start`.
- `ready`  in  1  downstream accepts current beat.
- `valid`  out  1  beat on outputs is meaningful.
- `img_addr`  out  AW  image element address, row-major.
- `ker_addr`  out  AW  kernel element address, row-major.
- `out_row`  out  AW  output row index of current window.
- `out_col`  out  AW  output column index of current window.
- `win_last`  out  1  current beat is the final tap (kr=F-1, kc=F-1) of its window.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after final beat accepted.
- `err`  out  1  one-cycle pulse when `start` arrives with `stride`=0.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN: `start`=1 and `stride`≠0. Latch stride; clear counters or, oc, kr, kc.
  - IDLE→IDLE: `start`=1 and `stride`=0. Pulse `err`; no beats are issued.
  - RUN→IDLE: final beat accepted. Pulse `done`.
- Output extent N = floor((M−F)/S)+1, where S is the latched stride. Total beats = N*N*F*F.
- Beat contents:
  - `img_addr` = (or*S+kr)*M + (oc*S+kc).
  - `ker_addr` = kr*F+kc.
  - `out_row`=or, `out_col`=oc.
  - `win_last` = (kr==F−1 && kc==F−1).
- Counter nesting, innermost first: kc, kr, oc, or. A counter wraps to 0 at its limit (F−1 for kc/kr, N−1 for oc/or) and carries into the next.
- Counters advance only on a handshake (`valid`&&`ready`).
- Arithmetic is done at AW+4 bits internally and truncated to AW. Legal parameters never overflow.
- `start` in RUN is ignored. Stride changes during RUN are ignored.
- S > M−F yields N=1: a single window at (0,0).

## Timing
- Reset values: `valid`=0, `busy`=0, `done`=0, `err`=0, `win_last`=0, all addresses and positions 0, state IDLE.
- `start` accepted at edge k → `busy`=1 and `valid`=1 with beat (0,0,0,0) valid after edge k; first beat visible in cycle k+1.
- Throughput: one beat per cycle while `ready`=1.
- `valid`&&!`ready`: all beat outputs are held stable; no counter moves.
- `valid` never drops without a handshake.
- Final beat accepted at edge j → after edge j, `valid`=0, `busy`=0, `done`=1 for exactly one cycle.
- A new `start` is accepted at edge j+1 at the earliest. `start` during the `done` cycle is accepted (state is IDLE).
- `err` is high for one cycle after the edge that samples the bad `start`.
- Reset asserted mid-RUN: immediately return to IDLE, all outputs at reset values, no `done`. After release, restart only on a new `start`.

## Test plan
- M=3, F=2, stride=1, `ready`=1 → 16 consecutive beats. img_addr sequence: 0,1,3,4 / 1,2,4,5 / 3,4,6,7 / 4,5,7,8. ker_addr repeats 0..3. `win_last` on beats 4, 8, 12, 16. `done` one cycle after beat 16.
- M=3, F=2, stride=2 → N=1: 4 beats (0,1,3,4), then `done`.
- M=5, F=3, stride=2 → N=2: 36 beats. Window (1,1) first img_addr=12 and last img_addr=24. `out_row`/`out_col` step (0,0),(0,1),(1,0),(1,1).
- M=3, F=2, stride=1, `ready` toggled 1,0,0,1,… → each beat is held unchanged through ready-low cycles. Sequence identical to scenario 1; total cycles = beats + stall cycles.
- `start` with stride=0 → `err` one-cycle pulse, `valid`/`busy` stay 0. Then `start` with stride=1 runs normally. `start` pulsed mid-RUN is ignored, with the beat count unchanged.
- Reset asserted after beat 6 of scenario 1 → outputs return to reset values immediately, no `done`. A fresh `start` restarts at beat (0,0,0,0).
